// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, functs, ALU operation codes and control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_write;
    logic    mem_read;
    logic    alu_src;
    logic    reg_dst;
    logic    is_branch;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  // R-type ALU selection; unknown functs fall back to add
  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SLL:          return ALU_SLL;
      FN_SRL:          return ALU_SRL;
      FN_SRA:          return ALU_SRA;
      FN_SUB, FN_SUBU: return ALU_SUB;
      FN_AND:          return ALU_AND;
      FN_OR:           return ALU_OR;
      FN_XOR:          return ALU_XOR;
      FN_NOR:          return ALU_NOR;
      FN_SLT:          return ALU_SLT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_decode_stage_register_file.sv
// Two-read, one-write register file with write-through bypass; r0 is hardwired to zero.
module register_file #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_q [REG_COUNT];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
    if (addr == '0)                   return '0;
    else if (wr_en && (waddr == addr)) return wdata;
    else                               return mem_q[addr];
  endfunction

  // Storage: cleared on reset, r0 never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read ports with same-cycle bypass of the write port
  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
  end

endmodule

// File: rtl/pipelined_decode_stage.sv
// MIPS ID stage: decode, immediate extension, hazard detection, ID branch resolution, ID/EX register.
module pipelined_decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned BRANCH_ID = 1,
  parameter int unsigned REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              if_flush,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              ex_valid,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_is_branch,
  output logic              ex_illegal,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd
);

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] pc4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } idex_t;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [DATA_W-1:0] imm_s, imm_z, imm;
  logic [DATA_W-1:0] br_target, j_target;
  ctrl_t             ctrl;
  logic              is_jump, use_rs, use_rt;
  logic [REG_AW-1:0] ex_dst;
  logic              load_use, br_haz, hazard, taken, redirect_int;
  idex_t             idex_d, idex_q;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[21 +: REG_AW];
  assign rt     = id_instr[16 +: REG_AW];
  assign rd     = id_instr[11 +: REG_AW];

  register_file #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .REG_AW(REG_AW)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (wb_reg_write),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // Control decode plus which source registers the instruction actually reads
  always_comb begin
    ctrl    = '0;
    is_jump = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.alu_op  = funct_to_alu(id_instr[5:0]);
        use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
        use_rs = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.is_branch = 1'b1; ctrl.alu_op = ALU_SUB;
        use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; use_rs = 1'b1; end
      OP_SLTI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; use_rs = 1'b1; end
      OP_ANDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; use_rs = 1'b1; end
      OP_ORI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  use_rs = 1'b1; end
      OP_LUI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LUI; end
      OP_J:    is_jump = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // Immediate extension and redirect targets
  always_comb begin
    imm_s = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
    imm_z = {{(DATA_W-16){1'b0}}, id_instr[15:0]};
    case (opcode)
      OP_ANDI, OP_ORI: imm = imm_z;
      OP_LUI:          imm = imm_z << 16;
      default:         imm = imm_s;
    endcase
    br_target = id_pc4 + (imm_s << 2);
    j_target  = {id_pc4[DATA_W-1:28], id_instr[25:0], 2'b00};
  end

  // Hazard detection, branch resolution and IF-side control
  always_comb begin
    ex_dst   = idex_q.ctrl.reg_dst ? idex_q.rd : idex_q.rt;
    load_use = id_valid && idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rt != '0) &&
               ((use_rs && (idex_q.rt == rs)) || (use_rt && (idex_q.rt == rt)));
    // No forwarding into ID: any pending producer of a branch operand stalls
    br_haz   = (BRANCH_ID != 0) && id_valid && ctrl.is_branch &&
               ((idex_q.valid && idex_q.ctrl.reg_write && (ex_dst != '0) &&
                 ((ex_dst == rs) || (ex_dst == rt))) ||
                ((mem_mem_read || mem_reg_write) && (mem_dst != '0) &&
                 ((mem_dst == rs) || (mem_dst == rt))));
    hazard   = load_use || br_haz;
    taken    = is_jump || (ctrl.is_branch && ((rs_data == rt_data) ^ (opcode == OP_BNE)));
    redirect_int = (BRANCH_ID != 0) && id_valid && !hazard && !ex_hold && taken;
    // Reset forces every combinational output low
    id_stall    = reset && (hazard || ex_hold);
    redirect    = reset && redirect_int;
    if_flush    = reset && redirect_int;
    redirect_pc = reset ? (is_jump ? j_target : br_target) : '0;
  end

  // ID/EX next state: hold, bubble or load the decoded instruction
  always_comb begin
    idex_d = idex_q;
    if (!ex_hold) begin
      idex_d = '0;
      if (id_valid && !hazard) begin
        idex_d.valid   = 1'b1;
        idex_d.ctrl    = ctrl;
        idex_d.imm     = imm;
        idex_d.rs_data = rs_data;
        idex_d.rt_data = rt_data;
        idex_d.pc4     = id_pc4;
        idex_d.rs      = rs;
        idex_d.rt      = rt;
        idex_d.rd      = rd;
      end
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ex_valid      = idex_q.valid;
  assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign ex_reg_write  = idex_q.ctrl.reg_write;
  assign ex_mem_write  = idex_q.ctrl.mem_write;
  assign ex_mem_read   = idex_q.ctrl.mem_read;
  assign ex_alu_src    = idex_q.ctrl.alu_src;
  assign ex_reg_dst    = idex_q.ctrl.reg_dst;
  assign ex_is_branch  = idex_q.ctrl.is_branch;
  assign ex_illegal    = idex_q.ctrl.illegal;
  assign ex_alu_op     = idex_q.ctrl.alu_op;
  assign ex_imm        = idex_q.imm;
  assign ex_rs_data    = idex_q.rs_data;
  assign ex_rt_data    = idex_q.rt_data;
  assign ex_pc4        = idex_q.pc4;
  assign ex_rs         = idex_q.rs;
  assign ex_rt         = idex_q.rt;
  assign ex_rd         = idex_q.rd;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: decode table plus multi-cycle hazard/reset sequences.
module tb_pipelined_decode_stage;
  import mips_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_pc4;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mem_reg_write, mem_mem_read;
  logic [REG_AW-1:0] mem_dst;
  logic              ex_hold;
  logic              id_stall, if_flush, redirect;
  logic [DATA_W-1:0] redirect_pc;
  logic              ex_valid, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read;
  logic              ex_alu_src, ex_reg_dst, ex_is_branch, ex_illegal;
  logic [3:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_imm, ex_rs_data, ex_rt_data, ex_pc4;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_decode_stage #(.DATA_W(DATA_W), .REG_COUNT(32), .BRANCH_ID(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .ex_hold(ex_hold), .id_stall(id_stall), .if_flush(if_flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .ex_valid(ex_valid), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_is_branch(ex_is_branch),
    .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        rw, mr, mw, asrc, rdst, br, ill;
    logic [3:0]  alu;
    logic [31:0] imm, rsd, rtd;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc4 = '0;
    wb_reg_write = 1'b0; wb_addr = '0; wb_data = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_dst = '0; ex_hold = 1'b0;

    // regs after preload: r1=5, r2=7, r5=0x1234, others 0
    vecs[0]  = '{"add",   rtype(1,2,4,FN_ADD),             32'h100, 1,0,0,0,1,0,0, ALU_ADD, 32'h2020,     5,  7, 0, 0};
    vecs[1]  = '{"lw",    itype(OP_LW,1,6,16'hFFFC),       32'h100, 1,1,0,1,0,0,0, ALU_ADD, 32'hFFFFFFFC, 5,  0, 0, 0};
    vecs[2]  = '{"sw",    itype(OP_SW,1,2,16'h0008),       32'h100, 0,0,1,1,0,0,0, ALU_ADD, 32'h8,        5,  7, 0, 0};
    vecs[3]  = '{"ori",   itype(OP_ORI,0,7,16'h8000),      32'h100, 1,0,0,1,0,0,0, ALU_OR,  32'h00008000, 0,  0, 0, 0};
    vecs[4]  = '{"andi",  itype(OP_ANDI,1,8,16'hFFFF),     32'h100, 1,0,0,1,0,0,0, ALU_AND, 32'h0000FFFF, 5,  0, 0, 0};
    vecs[5]  = '{"addi",  itype(OP_ADDI,1,9,16'hFFFF),     32'h100, 1,0,0,1,0,0,0, ALU_ADD, 32'hFFFFFFFF, 5,  0, 0, 0};
    vecs[6]  = '{"slti",  itype(OP_SLTI,2,10,16'h0010),    32'h100, 1,0,0,1,0,0,0, ALU_SLT, 32'h10,       7,  0, 0, 0};
    vecs[7]  = '{"lui",   itype(OP_LUI,0,11,16'h1234),     32'h100, 1,0,0,1,0,0,0, ALU_LUI, 32'h12340000, 0,  0, 0, 0};
    vecs[8]  = '{"ill",   32'hFFFFFFFF,                    32'h100, 0,0,0,0,0,0,1, ALU_ADD, 32'hFFFFFFFF, 0,  0, 0, 0};
    vecs[9]  = '{"beq_t", itype(OP_BEQ,1,1,16'h0004),      32'h100, 0,0,0,0,0,1,0, ALU_SUB, 32'h4,        5,  5, 1, 32'h110};
    vecs[10] = '{"bne_t", itype(OP_BNE,1,2,16'hFFFF),      32'h100, 0,0,0,0,0,1,0, ALU_SUB, 32'hFFFFFFFF, 5,  7, 1, 32'hFC};
    vecs[11] = '{"beq_n", itype(OP_BEQ,1,2,16'h0004),      32'h100, 0,0,0,0,0,1,0, ALU_SUB, 32'h4,        5,  7, 0, 0};
    vecs[12] = '{"j",     {OP_J, 26'h0000040},             32'h00400004, 0,0,0,0,0,0,0, ALU_ADD, 32'h40, 0, 0, 1, 32'h100};
    vecs[13] = '{"bne_n", itype(OP_BNE,2,2,16'h0008),      32'h100, 0,0,0,0,0,1,0, ALU_SUB, 32'h8,        7,  7, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_ctrl", {ex_reg_write, ex_mem_write, ex_mem_read, ex_illegal, ex_alu_op}, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_redirect", {id_stall, if_flush, redirect}, 0);
    reset = 1'b1;

    // WB bypass into same-cycle ID read
    wb_reg_write = 1'b1; wb_addr = 5; wb_data = 32'h1234;
    id_valid = 1'b1; id_instr = rtype(5,0,3,FN_ADD); id_pc4 = 32'h100;
    @(negedge clk);
    chk("bypass_rs", ex_rs_data, 32'h1234);
    chk("bypass_rt", ex_rt_data, 0);
    wb_addr = 0; wb_data = 32'hDEAD; id_instr = rtype(0,5,3,FN_ADD);
    @(negedge clk);
    chk("r0_rs", ex_rs_data, 0);
    chk("r5_rt", ex_rt_data, 32'h1234);
    id_valid = 1'b0; wb_addr = 1; wb_data = 5;
    @(negedge clk);
    wb_addr = 2; wb_data = 7;
    @(negedge clk);
    wb_reg_write = 1'b0;

    // Decode table
    for (int i = 0; i < 14; i++) begin
      id_valid = 1'b1; id_instr = vecs[i].instr; id_pc4 = vecs[i].pc4;
      #1;
      chk({vecs[i].name, "_stall"}, 32'(id_stall), 0);
      chk({vecs[i].name, "_redirect"}, 32'(redirect), 32'(vecs[i].redir));
      chk({vecs[i].name, "_flush"}, 32'(if_flush), 32'(vecs[i].redir));
      if (vecs[i].redir) chk({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].rpc);
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, 32'(ex_valid), 1);
      chk({vecs[i].name, "_ctrl"},
          {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_is_branch, ex_illegal},
          {vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].asrc, vecs[i].rdst, vecs[i].br, vecs[i].ill});
      chk({vecs[i].name, "_m2r"}, 32'(ex_mem_to_reg), 32'(vecs[i].mr));
      chk({vecs[i].name, "_alu"}, 32'(ex_alu_op), 32'(vecs[i].alu));
      chk({vecs[i].name, "_imm"}, ex_imm, vecs[i].imm);
      chk({vecs[i].name, "_rsd"}, ex_rs_data, vecs[i].rsd);
      chk({vecs[i].name, "_rtd"}, ex_rt_data, vecs[i].rtd);
      chk({vecs[i].name, "_pc4"}, ex_pc4, vecs[i].pc4);
    end

    // Load-use: LW r2 then ADD r4,r2,r1
    id_instr = itype(OP_LW,1,2,16'h0000); id_pc4 = 32'h100;
    @(negedge clk);
    id_instr = rtype(2,1,4,FN_ADD);
    #1;
    chk("lu_stall", 32'(id_stall), 1);
    chk("lu_redirect", 32'(redirect), 0);
    @(negedge clk);
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 0);
    #1;
    chk("lu_release", 32'(id_stall), 0);
    @(negedge clk);
    chk("lu_issue_valid", 32'(ex_valid), 1);
    chk("lu_issue_rd", 32'(ex_rd), 4);
    chk("lu_issue_rs", ex_rs_data, 7);

    // Branch hazards: MEM-stage producer, then EX-stage producer
    id_instr = itype(OP_BEQ,1,1,16'h0004); mem_reg_write = 1'b1; mem_dst = 1;
    #1;
    chk("bh_mem_stall", 32'(id_stall), 1);
    chk("bh_mem_redir", {if_flush, redirect}, 0);
    @(negedge clk);
    chk("bh_mem_bubble", 32'(ex_valid), 0);
    mem_reg_write = 1'b0; mem_dst = 0;
    #1;
    chk("bh_clear_redir", 32'(redirect), 1);
    chk("bh_clear_rpc", redirect_pc, 32'h110);
    @(negedge clk);
    id_instr = itype(OP_ADDI,1,1,16'h0000);
    @(negedge clk);
    id_instr = itype(OP_BEQ,1,1,16'h0004);
    #1;
    chk("bh_ex_stall", 32'(id_stall), 1);
    chk("bh_ex_redir", 32'(redirect), 0);
    @(negedge clk);
    chk("bh_ex_bubble", 32'(ex_valid), 0);

    // ex_hold freezes ID/EX and suppresses a jump redirect
    id_instr = itype(OP_ADDI,1,9,16'h0003); id_pc4 = 32'h200;
    @(negedge clk);
    id_instr = {OP_J, 26'h0000040}; id_pc4 = 32'h00400004; ex_hold = 1'b1;
    #1;
    chk("hold_redirect", {if_flush, redirect}, 0);
    chk("hold_stall", 32'(id_stall), 1);
    @(negedge clk);
    chk("hold_pc4", ex_pc4, 32'h200);
    chk("hold_imm", ex_imm, 32'h3);
    ex_hold = 1'b0;
    #1;
    chk("unhold_redirect", 32'(redirect), 1);
    chk("unhold_rpc", redirect_pc, 32'h00000100);
    @(negedge clk);
    chk("unhold_pc4", ex_pc4, 32'h00400004);

    // Asynchronous reset mid-run
    id_instr = itype(OP_ADDI,1,9,16'h0003); id_pc4 = 32'h200;
    @(negedge clk);
    id_instr = itype(OP_BEQ,1,1,16'h0004); id_pc4 = 32'h100;
    #1;
    chk("pre_rst_redirect", 32'(redirect), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 0);
    chk("mid_rst_imm", ex_imm, 0);
    chk("mid_rst_pc4", ex_pc4, 0);
    chk("mid_rst_comb", {id_stall, if_flush, redirect}, 0);
    chk("mid_rst_rpc", redirect_pc, 0);
    @(negedge clk);
    reset = 1'b1; id_instr = itype(OP_ADDI,1,9,16'h0003); id_pc4 = 32'h200;
    @(negedge clk);
    chk("post_rst_valid", 32'(ex_valid), 1);
    chk("post_rst_imm", ex_imm, 32'h3);
    chk("post_rst_rs", ex_rs_data, 0);

    id_valid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
